// File: rtl/fp_div_round_pack.sv
// Post-divider stage of the single-precision divider: normalizes the quotient,
// rounds to nearest-even and packs an IEEE-754 result with exception flags.
module fp_div_round_pack #(
    parameter int EXP_W = 10,
    parameter int Q_W   = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Q_W-1:0]   q_in,
    input  logic             q_inexact,
    input  logic             sign_in,
    input  logic [EXP_W-1:0] exp_in,
    input  logic [1:0]       special_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      result,
    output logic             flag_ovf,
    output logic             flag_unf,
    output logic             flag_inx,
    output logic             flag_err
);

    typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_t;

    localparam logic [1:0] CLS_NORM = 2'b00;
    localparam logic [1:0] CLS_ZERO = 2'b01;
    localparam logic [1:0] CLS_INF  = 2'b10;
    localparam logic [1:0] CLS_NAN  = 2'b11;

    localparam logic signed [EXP_W:0] EXP_ONE  = 1;
    localparam logic signed [EXP_W:0] EXP_ZERO = 0;
    localparam logic signed [EXP_W:0] EXP_MAX  = 255;

    typedef struct packed {
        logic             top;    // q[24] or any out-of-contract upper bit
        logic [23:0]      q;
        logic             inexact;
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [1:0]       cls;
    } cap_t;

    typedef struct packed {
        logic signed [EXP_W:0] exp;
        logic [22:0]           frac;
        logic                  g;
        logic                  s;
        logic                  sign;
        logic [1:0]            cls;
        logic                  err;
    } norm_t;

    state_t state, state_n;
    cap_t   cap;
    norm_t  nrm, nrm_d;

    // ---------------- control ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = NORM;
            end
            NORM:  state_n = ROUND;
            ROUND: state_n = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // ---------------- normalize ----------------
    logic signed [EXP_W:0] exp_ext;
    assign exp_ext = $signed({cap.exp[EXP_W-1], cap.exp});

    always_comb begin
        nrm_d      = '0;
        nrm_d.s    = cap.inexact;
        nrm_d.sign = cap.sign;
        nrm_d.cls  = cap.cls;
        nrm_d.exp  = exp_ext;
        if (cap.cls == CLS_NORM) begin
            if (cap.top) begin
                nrm_d.frac = cap.q[23:1];
                nrm_d.g    = cap.q[0];
            end else if (cap.q[23]) begin
                nrm_d.exp  = exp_ext - EXP_ONE;
                nrm_d.frac = cap.q[22:0];
            end else begin
                nrm_d.cls = CLS_NAN;
                nrm_d.err = 1'b1;
            end
        end
    end

    // ---------------- round and pack ----------------
    logic                  up, carry, inx;
    logic [22:0]           frac_r;
    logic signed [EXP_W:0] exp_r;
    logic [31:0]           pack_res;
    logic                  pack_ovf, pack_unf, pack_inx;

    assign up              = nrm.g & (nrm.s | nrm.frac[0]);
    assign {carry, frac_r} = {1'b0, nrm.frac} + {23'd0, up};
    assign exp_r           = carry ? nrm.exp + EXP_ONE : nrm.exp;
    assign inx             = nrm.g | nrm.s;

    always_comb begin
        pack_res = {nrm.sign, 31'd0};
        pack_ovf = 1'b0;
        pack_unf = 1'b0;
        pack_inx = 1'b0;
        case (nrm.cls)
            CLS_ZERO: pack_res = {nrm.sign, 31'd0};
            CLS_INF:  pack_res = {nrm.sign, 8'hFF, 23'd0};
            CLS_NAN:  pack_res = 32'h7FC0_0000;
            default: begin
                if (exp_r >= EXP_MAX) begin
                    pack_res = {nrm.sign, 8'hFF, 23'd0};
                    pack_ovf = 1'b1;
                    pack_inx = 1'b1;
                end else if (exp_r <= EXP_ZERO) begin
                    pack_res = {nrm.sign, 31'd0};
                    pack_unf = 1'b1;
                    pack_inx = 1'b1;
                end else begin
                    pack_res = {nrm.sign, exp_r[7:0], frac_r};
                    pack_inx = inx;
                end
            end
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap      <= '0;
            nrm      <= '0;
            result   <= '0;
            flag_ovf <= 1'b0;
            flag_unf <= 1'b0;
            flag_inx <= 1'b0;
            flag_err <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                cap.top     <= q_in[24] | (|q_in[Q_W-1:25]);
                cap.q       <= q_in[23:0];
                cap.inexact <= q_inexact;
                cap.sign    <= sign_in;
                cap.exp     <= exp_in;
                cap.cls     <= special_in;
            end
            if (state == NORM) nrm <= nrm_d;
            if (state == ROUND) begin
                result   <= pack_res;
                flag_ovf <= pack_ovf;
                flag_unf <= pack_unf;
                flag_inx <= pack_inx;
                flag_err <= nrm.err;
            end
        end
    end

endmodule

// File: tb/tb_fp_div_round_pack.sv
// Directed-vector bench: the driver queues expected results, a monitor pops and
// compares them on each output handshake.
module tb_fp_div_round_pack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [47:0] q_in;
    logic        q_inexact, sign_in;
    logic [9:0]  exp_in;
    logic [1:0]  special_in;
    logic        out_valid, out_ready;
    logic [31:0] result;
    logic        flag_ovf, flag_unf, flag_inx, flag_err;

    fp_div_round_pack #(.EXP_W(10), .Q_W(48)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .q_in(q_in), .q_inexact(q_inexact), .sign_in(sign_in),
        .exp_in(exp_in), .special_in(special_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result),
        .flag_ovf(flag_ovf), .flag_unf(flag_unf),
        .flag_inx(flag_inx), .flag_err(flag_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf, unf, inx, err;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    task automatic chk(input string name, input logic ok,
                       input logic [63:0] act, input logic [63:0] req);
        total_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    // monitor: compare whenever a handshake will occur at the next edge
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            exp_t got;
            got = '{result, flag_ovf, flag_unf, flag_inx, flag_err};
            if (sb.size() == 0) begin
                chk("unexpected_output", 1'b0, 64'(got), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result_flags", got == e, 64'(got), 64'(e));
            end
        end
    end

    task automatic send(input logic [47:0] q, input logic qi, input logic sg,
                        input logic [9:0] ex, input logic [1:0] sp,
                        input logic [31:0] r, input logic ovf, input logic unf,
                        input logic inx, input logic err);
        int cycles;
        @(posedge clk); #1;
        q_in = q; q_inexact = qi; sign_in = sg; exp_in = ex; special_in = sp;
        in_valid = 1'b1;
        chk("in_ready_idle", in_ready == 1'b1, 64'(in_ready), 64'd1);
        sb.push_back('{r, ovf, unf, inx, err});
        @(posedge clk); #1;
        in_valid = 1'b0;
        cycles = 1;
        while (!out_valid && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
        chk("latency", cycles == 3, 64'(cycles), 64'd3);
        if (out_ready) begin
            @(posedge clk); #1;
            chk("post_handshake", in_ready && !out_valid,
                64'({in_ready, out_valid}), 64'b10);
        end
    endtask

    initial begin
        logic [31:0] held;
        rst_n = 1'b0; in_valid = 1'b0; q_in = '0; q_inexact = 1'b0;
        sign_in = 1'b0; exp_in = '0; special_in = 2'b00; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state",
            in_ready && !out_valid && result == 32'd0 &&
            !flag_ovf && !flag_unf && !flag_inx && !flag_err,
            64'({in_ready, out_valid, flag_ovf, flag_unf, flag_inx, flag_err, result}),
            64'({6'b100000, 32'd0}));
        @(negedge clk) rst_n = 1'b1;

        //    q                qi    sg    exp     sp     result        ovf unf inx err
        send(48'h1000000,     1'b0, 1'b0, 10'd127, 2'b00, 32'h3F800000, 0, 0, 0, 0);
        send(48'hAAAAAA,      1'b1, 1'b0, 10'd127, 2'b00, 32'h3F2AAAAA, 0, 0, 1, 0);
        send(48'h1800000,     1'b0, 1'b0, 10'd127, 2'b00, 32'h3FC00000, 0, 0, 0, 0);
        send(48'h1FFFFFF,     1'b0, 1'b0, 10'd127, 2'b00, 32'h40000000, 0, 0, 1, 0);
        send(48'h1FFFFFF,     1'b0, 1'b1, 10'd254, 2'b00, 32'hFF800000, 1, 0, 1, 0);
        send(48'hC00000,      1'b0, 1'b0, 10'd0,   2'b00, 32'h00000000, 0, 1, 1, 0);
        send(48'h0,           1'b0, 1'b0, 10'd127, 2'b00, 32'h7FC00000, 0, 0, 0, 1);
        send(48'h1000000,     1'b0, 1'b1, 10'd127, 2'b11, 32'h7FC00000, 0, 0, 0, 0);
        send(48'h1000000,     1'b0, 1'b1, 10'd127, 2'b10, 32'hFF800000, 0, 0, 0, 0);
        send(48'h1000000,     1'b0, 1'b1, 10'd127, 2'b01, 32'h80000000, 0, 0, 0, 0);
        // tie with even lsb stays; tie with odd lsb rounds up
        send(48'h1000001,     1'b0, 1'b0, 10'd127, 2'b00, 32'h3F800000, 0, 0, 1, 0);
        send(48'h1000003,     1'b0, 1'b0, 10'd127, 2'b00, 32'h3F800002, 0, 0, 1, 0);
        // upper bits set without bit 24 take the bit-24 path
        send(48'h2000000,     1'b0, 1'b0, 10'd127, 2'b00, 32'h3F800000, 0, 0, 0, 0);
        send(48'hC00000,      1'b0, 1'b0, 10'd1,   2'b00, 32'h00000000, 0, 1, 1, 0);
        send(48'h1000000,     1'b0, 1'b0, 10'd254, 2'b00, 32'h7F000000, 0, 0, 0, 0);
        send(48'h1000000,     1'b0, 1'b1, 10'h3FB, 2'b00, 32'h80000000, 0, 1, 1, 0);

        // backpressure: output held, new input ignored
        out_ready = 1'b0;
        send(48'h1800000, 1'b0, 1'b0, 10'd127, 2'b00, 32'h3FC00000, 0, 0, 0, 0);
        held = result;
        q_in = 48'h1FFFFFF; exp_in = 10'd200; in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("backpressure_hold",
                out_valid && !in_ready && result == held && held == 32'h3FC00000,
                64'({out_valid, in_ready, result}), 64'({2'b10, 32'h3FC00000}));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("backpressure_release", in_ready && !out_valid,
            64'({in_ready, out_valid}), 64'b10);

        // reset while in ROUND: operation discarded
        @(posedge clk); #1;
        q_in = 48'h1FFFFFF; exp_in = 10'd127; sign_in = 1'b1; special_in = 2'b00;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("reset_mid_round", !out_valid && in_ready && result == 32'd0,
            64'({out_valid, in_ready, result}), 64'({2'b01, 32'd0}));
        @(negedge clk) rst_n = 1'b1;
        send(48'h1800000, 1'b0, 1'b1, 10'd128, 2'b00, 32'hC0400000, 0, 0, 0, 0);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) chk("drain_timeout", 1'b0, 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fp_div_round_pack.md
Name: fp_div_round_pack

Overview:
- Post-divider stage of the 32-bit floating-point divider.
- Consumes the 48-bit mantissa quotient from the non-restoring divider, plus the sign, pre-computed exponent and special-case code from the unpack stage.
- Normalizes the quotient, rounds it to nearest-even and packs an IEEE-754 single with exception flags.
- Multi-cycle FSM with valid/ready handshakes on both sides.

Parameters:
- EXP_W, 10, width of signed exponent input (two's complement)
- Q_W, 48, quotient width from divider

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream operands valid
- in_ready  out  1  block can accept
- q_in  in  Q_W  quotient = floor({mantA,24'b0}/{24'b0,mantB}), mantA/mantB with hidden bit
- q_inexact  in  1  divider remainder nonzero (tie 0 if unavailable)
- sign_in  in  1  signA ^ signB
- exp_in  in  EXP_W  signed expA - expB + 127
- special_in  in  2  00 normal, 01 zero, 10 infinity, 11 NaN
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- result  out  32  packed IEEE-754 single
- flag_ovf  out  1  overflow to infinity
- flag_unf  out  1  underflow flushed to zero
- flag_inx  out  1  result inexact
- flag_err  out  1  normal-class quotient had neither bit 24 nor bit 23 set

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=1; out_valid=0; result=0; all flags=0. Mid-operation reset aborts the operation and discards captured operands.
- FSM states: IDLE, NORM, ROUND, OUT.
- IDLE: in_ready=1. On in_valid&in_ready, register all inputs and go to NORM. in_ready=0 in all other states.
- NORM (one cycle), for normal class:
  - q[24]=1: exp=exp_in, frac={q[23:1]}, G=q[0].
  - else q[23]=1: exp=exp_in-1, frac=q[22:0], G=0.
  - Neither bit set: flag_err=1, class forced to NaN.
  - q[47:25] nonzero is out of contract; treat it as the q[24] case and ignore the upper bits.
  - Sticky S=q_inexact. Exponent arithmetic is EXP_W+1 bits signed, with no wrap.
- ROUND (one cycle):
  - up = G & (S | frac[0]).
  - {c,frac} = frac + up. If c=1: frac=0, exp=exp+1.
  - inx = G | S.
- Pack at the end of ROUND, registered into result and flags on entry to OUT:
  - zero class: {sign,31'b0}, no flags.
  - infinity class: {sign,8'hFF,23'b0}, no flags.
  - NaN class: 32'h7FC00000 (sign ignored).
  - normal, exp >= 255: {sign,8'hFF,23'b0}, flag_ovf=1, flag_inx=1.
  - normal, exp <= 0: {sign,31'b0}, flag_unf=1, flag_inx=1. No denormals.
  - normal otherwise: {sign,exp[7:0],frac}, flag_inx=inx.
- OUT: out_valid=1. result and flags are held stable until out_ready=1. On out_valid&out_ready, out_valid drops at that edge and the FSM returns to IDLE.
- Latency: out_valid rises at the 3rd rising edge after (and including) the accepting edge.
- Throughput: one result per 4 cycles minimum when out_ready=1 (accept edge, NORM, ROUND, OUT handshake). Back-to-back input is accepted on the cycle after the OUT handshake.
- Flags and result are valid only while out_valid=1; they retain their last values otherwise.

Test Plan:
- 1.0/1.0: q_in=48'h1000000, exp_in=127, sign 0, q_inexact=0, out_ready=1 -> result 32'h3F800000, no flags, out_valid exactly 3 edges after accept, in_ready back to 1 after handshake.
- 1.0/1.5: q_in=48'hAAAAAA, exp_in=127, q_inexact=1 -> result 32'h3F2AAAAA, flag_inx=1. Also 1.5/1.0: q_in=48'h1800000 -> 32'h3FC00000.
- Rounding carry: q_in=48'h1FFFFFF, exp_in=127 -> G=1, lsb=1, mantissa wraps -> result 32'h40000000, flag_inx=1.
- Overflow/underflow:
  - q_in=48'h1FFFFFF, exp_in=254, sign=1 -> 32'hFF800000, flag_ovf=1.
  - q_in=48'hC00000, exp_in=0 -> 32'h00000000, flag_unf=1.
  - q_in=0, normal class -> 32'h7FC00000, flag_err=1.
- Specials: special_in=11 -> 32'h7FC00000. special_in=10 with sign=1 -> 32'hFF800000. special_in=01 with sign=1 -> 32'h80000000.
- Backpressure/reset:
  - Hold out_ready=0 for 5 cycles -> result and out_valid stable, in_ready=0, new in_valid ignored.
  - Assert rst_n=0 while in ROUND -> out_valid=0, in_ready=1 immediately; next operation completes correctly.
